nukv_rotation_sched: RTL

//  Command-driven sequencer in front of the privacy rotation path. Per command it either steers a value

---
 rtl/nukv_rotation_sched.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/nukv_rotation_sched.sv
// Command sequencer in front of the rotation path: steers value words into the matrix
// buffer (load) or to the rotation engine (rotate), and tracks matrix residency.
//
// state       | meaning
// S_IDLE      | waiting for a command, cmd_ready high
// S_LOAD      | forwarding matrix words to the buffer, dropping any excess words
// S_LOAD_WAIT | all load words taken, waiting for the buffer's matrix_last
// S_FLUSH     | one-cycle buffer flush after a truncated load
// S_ROTATE    | passing value words to the rotation engine
// S_DISCARD   | draining a rotate command that arrived with no matrix resident
module nukv_rotation_sched #(
  parameter int MEMORY_WIDTH        = 512,
  parameter int COL_COUNT           = 3,
  parameter int COL_WIDTH           = 64,
  parameter int VALUE_SIZE_BYTES_NO = 2,
  parameter int CNT_WIDTH           = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_cmd_valid,
  output logic                    o_cmd_ready,
  input  logic                    i_cmd_load,
  input  logic [CNT_WIDTH-1:0]    i_cmd_words,
  input  logic [MEMORY_WIDTH-1:0] i_in_data,
  input  logic                    i_in_valid,
  output logic                    o_in_ready,
  output logic [MEMORY_WIDTH-1:0] o_buf_data,
  output logic                    o_buf_valid,
  input  logic                    i_buf_ready,
  input  logic                    i_buf_matrix_last,
  output logic                    o_buf_flush,
  output logic [MEMORY_WIDTH-1:0] o_rot_data,
  output logic                    o_rot_valid,
  input  logic                    i_rot_ready,
  output logic                    o_rot_last,
  output logic                    o_matrix_loaded,
  output logic                    o_err
);

  localparam int MB = COL_COUNT * COL_COUNT * COL_WIDTH;
  localparam int FB = MEMORY_WIDTH - 8 * VALUE_SIZE_BYTES_NO;
  localparam int LOAD_WORDS = (MB <= FB) ? 1 : 1 + (MB - FB + MEMORY_WIDTH - 1) / MEMORY_WIDTH;
  localparam logic [CNT_WIDTH-1:0] LOAD_WORDS_C = CNT_WIDTH'(LOAD_WORDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_LOAD_WAIT,
    S_FLUSH,
    S_ROTATE,
    S_DISCARD
  } state_t;

  state_t                 r_state;
  logic [CNT_WIDTH-1:0]   r_cnt;
  logic [CNT_WIDTH-1:0]   r_words;
  logic                   r_loaded;
  logic                   r_got_last;
  logic                   r_err;

  logic w_last;
  logic w_fwd;
  logic w_cmd_ready;
  logic w_in_ready;
  logic w_buf_valid;
  logic w_rot_valid;
  logic w_rot_last;
  logic w_accept;

  assign w_last   = (r_cnt == r_words - CNT_WIDTH'(1));
  assign w_fwd    = (r_cnt < LOAD_WORDS_C);
  assign w_accept = i_in_valid & w_in_ready;

  always_comb begin
    w_cmd_ready = 1'b0;
    w_in_ready  = 1'b0;
    w_buf_valid = 1'b0;
    w_rot_valid = 1'b0;
    w_rot_last  = 1'b0;
    case (r_state)
      S_IDLE:    w_cmd_ready = 1'b1;
      S_LOAD: begin
        if (w_fwd) begin
          w_buf_valid = i_in_valid;
          w_in_ready  = i_buf_ready;
        end else begin
          w_in_ready  = 1'b1;
        end
      end
      S_ROTATE: begin
        w_rot_valid = i_in_valid;
        w_in_ready  = i_rot_ready;
        w_rot_last  = w_last;
      end
      S_DISCARD: w_in_ready = 1'b1;
      default:   ;
    endcase
  end

  // Reset gates every handshake so an abandoned command consumes nothing more.
  assign o_cmd_ready     = w_cmd_ready & ~rst;
  assign o_in_ready      = w_in_ready & ~rst;
  assign o_buf_valid     = w_buf_valid & ~rst;
  assign o_rot_valid     = w_rot_valid & ~rst;
  assign o_rot_last      = w_rot_last & ~rst;
  assign o_matrix_loaded = r_loaded & ~rst;
  assign o_err           = r_err & ~rst;
  assign o_buf_flush     = rst | (r_state == S_FLUSH);
  assign o_buf_data      = i_in_data;
  assign o_rot_data      = i_in_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_words    <= '0;
      r_loaded   <= 1'b0;
      r_got_last <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_cmd_valid) begin
            r_words <= i_cmd_words;
            r_cnt   <= '0;
            if (i_cmd_load) begin
              r_loaded   <= 1'b0;
              r_got_last <= 1'b0;
              if (i_cmd_words == '0) begin
                r_err   <= 1'b1;
                r_state <= S_FLUSH;
              end else begin
                r_state <= S_LOAD;
              end
            end else if (i_cmd_words != '0) begin
              if (r_loaded) begin
                r_state <= S_ROTATE;
              end else begin
                r_err   <= 1'b1;
                r_state <= S_DISCARD;
              end
            end
          end
        end
        S_LOAD: begin
          if (i_buf_matrix_last) r_got_last <= 1'b1;
          if (w_accept) begin
            r_cnt <= r_cnt + CNT_WIDTH'(1);
            if (w_last) begin
              if (r_words < LOAD_WORDS_C) begin
                r_err   <= 1'b1;
                r_state <= S_FLUSH;
              end else begin
                r_state <= S_LOAD_WAIT;
              end
            end
          end
        end
        S_LOAD_WAIT: begin
          if (r_got_last | i_buf_matrix_last) begin
            r_got_last <= 1'b1;
            r_loaded   <= 1'b1;
            r_state    <= S_IDLE;
          end
        end
        S_FLUSH: r_state <= S_IDLE;
        S_ROTATE, S_DISCARD: begin
          if (w_accept) begin
            r_cnt <= r_cnt + CNT_WIDTH'(1);
            if (w_last) r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
